// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift normalizer.
//   WIDTH / SHW  : default data width and shift-amount width
//   DIR_LEFT     : normalize toward the MSB (leading-zero count, left shift)
//   DIR_RIGHT    : normalize toward the LSB (trailing-zero count, right shift)
//   norm_result_t: one normalized result {data, shift, dir, zero}
package shift_norm_pkg;

    localparam int WIDTH = 8;
    localparam int SHW   = $clog2(WIDTH);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shift;
        logic             dir;
        logic             zero;
    } norm_result_t;

endpackage

// File: rtl/shift_normalizer_if.sv
// Handshake bundle for the shift normalizer.
//   in_valid/in_ready/in_data/in_dir      : upstream word and direction
//   out_valid/out_ready/out_data/out_shift: normalized word and shift used
//   out_dir/out_zero                      : direction carried along, all-zero flag
// slave  = the normalizer's view, master = the producer/consumer's view.
interface shift_normalizer_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_shift;
    logic             out_dir;
    logic             out_zero;

    modport slave (
        input  in_valid, in_data, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_dir, out_zero
    );

    modport master (
        output in_valid, in_data, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_dir, out_zero
    );
endinterface

// File: rtl/shift_normalizer_zero_count.sv
// Combinational priority encoder counting the zeros in front of the first
// set bit, scanned from the MSB (dir=0) or from the LSB (dir=1).
//   data_i  : word to scan
//   dir_i   : DIR_LEFT = leading zeros, DIR_RIGHT = trailing zeros
//   count_o : zero count (0 when data_i is all zeros)
//   zero_o  : data_i is all zeros
module zero_count #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    output logic [SHW-1:0]   count_o,
    output logic             zero_o
);
    import shift_norm_pkg::*;

    logic [SHW-1:0] lead_cnt;
    logic [SHW-1:0] trail_cnt;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        lead_cnt  = '0;
        trail_cnt = '0;
        // Later loop iterations override earlier ones, so the highest set bit
        // wins for the leading count and the lowest set bit for the trailing.
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) lead_cnt = SHW'(WIDTH - 1 - i);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data_i[i]) trail_cnt = SHW'(i);
        end
    end

    assign count_o = (dir_i == DIR_RIGHT) ? trail_cnt : lead_cnt;
    assign zero_o  = ~|data_i;

endmodule

// File: rtl/shift_normalizer.sv
// Two-stage normalizer: stage 1 registers the word with its zero count,
// stage 2 registers the word shifted so the first one sits at the MSB
// (dir=0) or LSB (dir=1). Valid/ready on both sides, bubbles collapse,
// at most two words in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : shift_normalizer_if.slave handshake bundle
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_normalizer_if.slave    io
);
    import shift_norm_pkg::*;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s1_dir_q,   s1_dir_d;
    logic [SHW-1:0]   s1_cnt_q,   s1_cnt_d;
    logic             s1_zero_q,  s1_zero_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [SHW-1:0]   s2_shift_q, s2_shift_d;
    logic             s2_dir_q,   s2_dir_d;
    logic             s2_zero_q,  s2_zero_d;

    logic [SHW-1:0]   zc_count;
    logic             zc_zero;
    logic             s2_take;
    logic             in_fire;

    zero_count #(.WIDTH(WIDTH), .SHW(SHW)) u_zero_count (
        .data_i  (io.in_data),
        .dir_i   (io.in_dir),
        .count_o (zc_count),
        .zero_o  (zc_zero)
    );

    // Stage 2 can take a word when empty or when its word leaves this cycle.
    assign s2_take     = ~s2_valid_q | io.out_ready;
    // Equivalent to "stage 1 empty or stage 1 moving"; independent of in_valid.
    assign io.in_ready = ~s1_valid_q | ~s2_valid_q | io.out_ready;
    assign in_fire     = io.in_valid & io.in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_dir_d   = s1_dir_q;
        s1_cnt_d   = s1_cnt_q;
        s1_zero_d  = s1_zero_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_shift_d = s2_shift_q;
        s2_dir_d   = s2_dir_q;
        s2_zero_d  = s2_zero_q;

        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                // Zero input has count 0, so it passes through as 0.
                s2_data_d  = (s1_dir_q == DIR_LEFT) ? (s1_data_q << s1_cnt_q)
                                                    : (s1_data_q >> s1_cnt_q);
                s2_shift_d = s1_cnt_q;
                s2_dir_d   = s1_dir_q;
                s2_zero_d  = s1_zero_q;
            end
        end

        if (io.in_ready) begin
            s1_valid_d = io.in_valid;
            if (in_fire) begin
                s1_data_d = io.in_data;
                s1_dir_d  = io.in_dir;
                s1_cnt_d  = zc_count;
                s1_zero_d = zc_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well, not only the
            // valids, so every output reads 0 straight out of reset.
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_dir_q   <= 1'b0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_shift_q <= '0;
            s2_dir_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so both stages update from the
            // pre-edge values and a word advances exactly one stage per edge.
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_dir_q   <= s1_dir_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_shift_q <= s2_shift_d;
            s2_dir_q   <= s2_dir_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign io.out_valid = s2_valid_q;
    assign io.out_data  = s2_data_q;
    assign io.out_shift = s2_shift_q;
    assign io.out_dir   = s2_dir_q;
    assign io.out_zero  = s2_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed cases with literal
// expectations, backpressure and mid-flight reset, then 1000 random words
// with random valid/ready throttling against a behavioural model.
module tb_shift_normalizer;
    import shift_norm_pkg::*;

    localparam int NUM_RANDOM = 1000;

    typedef struct packed {
        logic [WIDTH-1:0] orig;
        norm_result_t     exp;
    } entry_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    entry_t q[$];

    shift_normalizer_if #(.WIDTH(WIDTH)) bus ();

    shift_normalizer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Normalize by repeatedly shifting until the wanted end holds a one.
    function automatic norm_result_t ref_norm(input logic [WIDTH-1:0] d, input logic dir);
        norm_result_t r;
        r.data  = d;
        r.shift = '0;
        r.dir   = dir;
        r.zero  = (d == '0);
        if (d != '0) begin
            if (dir == DIR_LEFT) begin
                while (!r.data[WIDTH-1]) begin
                    r.data  = r.data << 1;
                    r.shift = r.shift + 1'b1;
                end
            end else begin
                while (!r.data[0]) begin
                    r.data  = r.data >> 1;
                    r.shift = r.shift + 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Monitor: in_ready rule, output compare against the model queue,
    // round trip through an opposite-direction barrel shift.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            check("in_ready_rule", 32'(bus.in_ready),
                  32'(!(q.size() == 2 && !bus.out_ready)));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("out_data",  32'(bus.out_data),  32'(q[0].exp.data));
                    check("out_shift", 32'(bus.out_shift), 32'(q[0].exp.shift));
                    check("out_dir",   32'(bus.out_dir),   32'(q[0].exp.dir));
                    check("out_zero",  32'(bus.out_zero),  32'(q[0].exp.zero));
                    if (bus.out_ready) begin
                        if (!bus.out_zero)
                            check("round_trip",
                                  32'((bus.out_dir == DIR_LEFT) ? (bus.out_data >> bus.out_shift)
                                                                : (bus.out_data << bus.out_shift)),
                                  32'(q[0].orig));
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{orig: bus.in_data, exp: ref_norm(bus.in_data, bus.in_dir)});
        end
    end

    // Waits for acceptance of the word already on the bus, then drops valid.
    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic dir);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dir   = dir;
        wait_accept();
    endtask

    // Two-cycle latency with a free output: result visible one edge after
    // the edge following acceptance.
    task automatic send_and_check(input string name, input logic [WIDTH-1:0] d, input logic dir,
                                  input logic [WIDTH-1:0] ed, input int es, input logic ez);
        send(d, dir);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_data"},  32'(bus.out_data),  32'(ed));
        check({name, "_shift"}, 32'(bus.out_shift), 32'(es));
        check({name, "_zero"},  32'(bus.out_zero),  32'(ez));
    endtask

    task automatic drain();
        bit ok = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && !bus.out_valid) begin ok = 1; break; end
        end
        check("drain_done", 32'(ok), 32'd1);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] d;
        case ($urandom_range(3))
            0:       d = WIDTH'(1) << $urandom_range(WIDTH - 1);
            1:       d = ($urandom_range(3) == 0) ? '0 : WIDTH'($urandom);
            default: d = WIDTH'($urandom);
        endcase
        return d;
    endfunction

    initial begin
        norm_result_t r;
        int sent, cyc;
        bit acc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_shift", 32'(bus.out_shift), 32'd0);
        check("rst_out_zero",  32'(bus.out_zero),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Pin the model with hand-computed values.
        r = ref_norm(8'h10, DIR_LEFT);  check("model_10_l", 32'({r.data, r.shift}), 32'({8'h80, 3'd3}));
        r = ref_norm(8'h0A, DIR_RIGHT); check("model_0a_r", 32'({r.data, r.shift}), 32'({8'h05, 3'd1}));
        r = ref_norm(8'h80, DIR_RIGHT); check("model_80_r", 32'({r.data, r.shift}), 32'({8'h01, 3'd7}));
        r = ref_norm(8'h04, DIR_LEFT);  check("model_04_l", 32'({r.data, r.shift}), 32'({8'h80, 3'd5}));
        r = ref_norm(8'h00, DIR_RIGHT); check("model_00_r", 32'({r.data, r.shift, r.zero}), 32'({8'h00, 3'd0, 1'b1}));

        // Directed cases with the output always ready.
        send_and_check("d10_left",  8'h10, DIR_LEFT,  8'h80, 3, 1'b0);
        send_and_check("d0a_right", 8'h0A, DIR_RIGHT, 8'h05, 1, 1'b0);
        send_and_check("d80_right", 8'h80, DIR_RIGHT, 8'h01, 7, 1'b0);
        send_and_check("d01_left",  8'h01, DIR_LEFT,  8'h80, 7, 1'b0);
        send_and_check("d00_left",  8'h00, DIR_LEFT,  8'h00, 0, 1'b1);
        send_and_check("d00_right", 8'h00, DIR_RIGHT, 8'h00, 0, 1'b1);
        send_and_check("daa_left",  8'hAA, DIR_LEFT,  8'hAA, 0, 1'b0);
        send_and_check("d01_right", 8'h01, DIR_RIGHT, 8'h01, 0, 1'b0);
        drain();

        // Backpressure: two words fill the pipe, the third must stall.
        bus.out_ready = 1'b0;
        send(8'h01, DIR_LEFT);
        send(8'h02, DIR_LEFT);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h04;
        bus.in_dir   = DIR_LEFT;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_hold_data",    32'(bus.out_data), 32'h80);
            check("bp_hold_shift",   32'(bus.out_shift), 32'd7);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_accept();
        drain();
        check("bp_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of two words in flight.
        bus.out_ready = 1'b0;
        send(8'h20, DIR_LEFT);
        send(8'h40, DIR_RIGHT);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data",  32'(bus.out_data),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready),  32'd1);

        // Random traffic with throttling on both sides.
        sent = 0;
        cyc  = 0;
        acc  = 0;
        while (sent < NUM_RANDOM && cyc < 20000) begin
            @(posedge clk); #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(9) < 7);
                bus.in_data  = rand_word();
                bus.in_dir   = 1'($urandom_range(1));
            end
            bus.out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            cyc++;
        end
        check("random_all_sent", 32'(sent), 32'(NUM_RANDOM));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Inverse companion of the combinational 8-bit barrel shifter: it derives the shift amount from the data rather than applying a given amount.
- Takes a data word and a direction, finds the leading one (dir=0) or trailing one (dir=1), and shifts the word so that one lands at the MSB or LSB. It returns the normalized word and the shift amount used.
- Two-stage pipeline with valid/ready on both sides. Sits between a data producer and the barrel shifter / priority-encoder datapath.
- Feeding out_data, out_shift and the opposite dir back into the barrel shifter reproduces in_data.

Parameters:
- WIDTH, 8, data width in bits (power of 2, >=4).
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  word to normalize.
- in_dir  input  1  0 = normalize toward MSB (left shift); 1 = normalize toward LSB (right shift).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  normalized word.
- out_shift  output  SHW  positions shifted: leading-zero count (dir=0) or trailing-zero count (dir=1).
- out_dir  output  1  in_dir carried with the word.
- out_zero  output  1  in_data was all zeros.

Behaviour:
- Reset (async, rst_n=0): all stage valids clear; out_valid=0, out_data=0, out_shift=0, out_dir=0, out_zero=0; in_ready=1 from the first cycle after reset release.
- Handshake: a transfer occurs on a clk edge with valid&ready.
  - in_ready = ~s1_valid | ~s2_valid | out_ready. The combinational path out_ready->in_ready is permitted.
  - in_ready never depends on in_valid.
  - out_valid, once high, holds with stable out_* until out_ready=1.
- Stage 1, on accept: register in_data and in_dir; compute the count via the zero-count sub-module; register the count and the zero flag.
- Stage 2: register the shifted result.
  - dir=0: data << count.
  - dir=1: data >> count.
  - Zero fill in both cases; no rotation.
- Stage advance rules:
  - s1 moves to s2 when s2 is empty or s2 is being consumed.
  - s1 loads from the input when s1 is empty or s1 is moving.
  - Bubbles collapse.
- Latency: 2 cycles from input accept to out_valid with no backpressure. Throughput: 1 word/cycle.
- Zero input: out_data=0, out_shift=0, out_zero=1 (dir ignored).
- Already-normalized input (MSB set with dir=0, or LSB set with dir=1): out_shift=0, out_data=in_data.
- Maximum shift: single bit at the opposite end gives out_shift=WIDTH-1.
- Ordering is strictly FIFO. No word is dropped or duplicated under any out_ready pattern.
- Buffering: at most 2 words in flight. When both stages are full and out_ready=0, in_ready=0.
- Simultaneous accept and emit in the same cycle with a full pipeline is legal and sustains throughput.
- Reset asserted mid-operation discards all in-flight words; no output handshake follows for them.

Decomposition:
- Package shift_norm_pkg:
  - WIDTH, SHW defaults.
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Result struct/typedef {data, shift, dir, zero}.
- Sub-module zero_count (combinational): inputs data and dir; outputs count[SHW] and zero. Counts leading zeros for dir=0 and trailing zeros for dir=1, built as a priority encoder.
- Shifting is done inline in stage 2.

Test Plan:
- 8'h10, dir=0, out_ready=1 -> two cycles later: out_data=8'h80, out_shift=3, out_zero=0.
- 8'b0000_1010, dir=1 -> out_data=8'b0000_0101, out_shift=1. Then 8'h80, dir=1 -> out_data=8'h01, out_shift=7.
- Single-bit and degenerate inputs:
  - 8'h01, dir=0 -> out_data=8'h80, out_shift=7.
  - 8'h00, either dir -> out_data=0, out_shift=0, out_zero=1.
  - 8'hAA, dir=0 -> unchanged, out_shift=0.
- Backpressure:
  - out_ready=0; present 8'h01, 8'h02, 8'h04 back-to-back with dir=0.
  - Expect in_ready=0 after two accepts.
  - Release out_ready -> outputs 8'h80/7, 8'h80/6, 8'h80/5 in order, then in_ready=1.
- Reset mid-flight: two words accepted, rst_n pulsed low -> out_valid=0 immediately, no stale output after release.
- Round-trip random: 1000 words with random valid/ready throttling. Feed out_data with out_shift and the inverted dir into the barrel shifter -> equals original in_data whenever out_zero=0.
